// File: rtl/axi_sram_responder_if.sv
// AXI4 bus interface with master and slave views, parameterised by ID, address,
// data and user widths.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 slave backed by a word-addressed SRAM. Independent read and write FSMs,
// one outstanding burst each, INCR/FIXED bursts, per-beat SLVERR reporting.
module axi_sram_responder #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned MEM_WORDS      = 1024
) (
    input logic   clk,
    input logic   rst_n,
    AXI_BUS.Slave slv
);
    localparam int unsigned DATA_BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(DATA_BYTES);
    localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
    localparam int unsigned AW         = AXI_ADDR_WIDTH;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLV   = 2'b10;
    localparam logic [1:0]  BURST_FIX  = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> (IDX_W + OFF_W)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        return a[IDX_W+OFF_W-1:OFF_W];
    endfunction

    // INCR steps from the size-aligned address, so an unaligned beat 0 realigns.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                                input logic [1:0] burst);
        logic [AW-1:0] step;
        step = AW'(1) << size;
        if (burst == BURST_FIX) return a;
        return (a & ~(step - AW'(1))) + step;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Write channel state
    w_state_e                w_state_q, w_state_d;
    logic                    aw_ready_q, aw_ready_d;
    logic                    w_ready_q, w_ready_d;
    logic                    b_valid_q, b_valid_d;
    logic [1:0]              b_resp_q, b_resp_d;
    logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
    logic [AW-1:0]           w_addr_q, w_addr_d;
    logic [7:0]              w_len_q, w_len_d;
    logic [2:0]              w_size_q, w_size_d;
    logic [1:0]              w_burst_q, w_burst_d;
    logic [7:0]              w_cnt_q, w_cnt_d;
    logic                    w_err_q, w_err_d;
    logic                    w_beat_last, w_beat_ok, mem_we;

    always_comb begin
        w_state_d   = w_state_q;
        aw_ready_d  = aw_ready_q;
        w_ready_d   = w_ready_q;
        b_valid_d   = b_valid_q;
        b_resp_d    = b_resp_q;
        w_id_d      = w_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_size_d    = w_size_q;
        w_burst_d   = w_burst_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        mem_we      = 1'b0;
        w_beat_last = (w_cnt_q == w_len_q);
        w_beat_ok   = in_range(w_addr_q) && !w_burst_q[1];
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready_d = 1'b1;
                if (slv.aw_valid && aw_ready_q) begin
                    w_id_d     = slv.aw_id;
                    w_addr_d   = slv.aw_addr;
                    w_len_d    = slv.aw_len;
                    w_size_d   = slv.aw_size;
                    w_burst_d  = slv.aw_burst;
                    w_cnt_d    = 8'd0;
                    w_err_d    = 1'b0;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (slv.w_valid && w_ready_q) begin
                    mem_we   = w_beat_ok;
                    w_err_d  = w_err_q | !w_beat_ok | (slv.w_last != w_beat_last);
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    // The beat count, not w_last, closes the burst.
                    if (w_beat_last) begin
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_resp_d  = w_err_d ? RESP_SLV : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (slv.b_ready && b_valid_q) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_len_q    <= 8'd0;
            w_size_q   <= 3'd0;
            w_burst_q  <= 2'b00;
            w_cnt_q    <= 8'd0;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            w_id_q     <= w_id_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_size_q   <= w_size_d;
            w_burst_q  <= w_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            for (int i = 0; i < int'(DATA_BYTES); i++) begin
                if (slv.w_strb[i]) mem[word_idx(w_addr_q)][8*i +: 8] <= slv.w_data[8*i +: 8];
            end
        end
    end

    // Read channel state
    r_state_e                  r_state_q, r_state_d;
    logic                      ar_ready_q, ar_ready_d;
    logic                      r_valid_q, r_valid_d;
    logic                      r_last_q, r_last_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]                r_resp_q, r_resp_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [AW-1:0]             r_addr_q, r_addr_d;
    logic [7:0]                r_len_q, r_len_d;
    logic [2:0]                r_size_q, r_size_d;
    logic [1:0]                r_burst_q, r_burst_d;
    logic [7:0]                r_cnt_q, r_cnt_d;
    logic [AW-1:0]             fetch_addr;
    logic [1:0]                fetch_burst;
    logic                      fetch_ok;
    logic [AXI_DATA_WIDTH-1:0] fetch_data;

    // The beat about to be presented is fetched into registered R outputs, so a
    // same-cycle write to that word is seen only by later beats.
    always_comb begin
        fetch_addr  = (r_state_q == R_IDLE) ? slv.ar_addr
                                            : next_addr(r_addr_q, r_size_q, r_burst_q);
        fetch_burst = (r_state_q == R_IDLE) ? slv.ar_burst : r_burst_q;
        fetch_ok    = in_range(fetch_addr) && !fetch_burst[1];
        fetch_data  = fetch_ok ? mem[word_idx(fetch_addr)] : '0;
    end

    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        r_id_d     = r_id_q;
        r_addr_d   = r_addr_q;
        r_len_d    = r_len_q;
        r_size_d   = r_size_q;
        r_burst_d  = r_burst_q;
        r_cnt_d    = r_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (slv.ar_valid && ar_ready_q) begin
                    r_id_d     = slv.ar_id;
                    r_addr_d   = slv.ar_addr;
                    r_len_d    = slv.ar_len;
                    r_size_d   = slv.ar_size;
                    r_burst_d  = slv.ar_burst;
                    r_cnt_d    = 8'd0;
                    r_valid_d  = 1'b1;
                    r_last_d   = (slv.ar_len == 8'd0);
                    r_data_d   = fetch_data;
                    r_resp_d   = fetch_ok ? RESP_OKAY : RESP_SLV;
                    ar_ready_d = 1'b0;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (slv.r_ready && r_valid_q) begin
                    if (r_cnt_q == r_len_q) begin
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                        r_state_d  = R_IDLE;
                    end else begin
                        r_addr_d = fetch_addr;
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
                        r_data_d = fetch_data;
                        r_resp_d = fetch_ok ? RESP_OKAY : RESP_SLV;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= 2'b00;
            r_id_q     <= '0;
            r_addr_q   <= '0;
            r_len_q    <= 8'd0;
            r_size_q   <= 3'd0;
            r_burst_q  <= 2'b00;
            r_cnt_q    <= 8'd0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_id_q     <= r_id_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_size_q   <= r_size_d;
            r_burst_q  <= r_burst_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    assign slv.aw_ready = aw_ready_q;
    assign slv.w_ready  = w_ready_q;
    assign slv.b_valid  = b_valid_q;
    assign slv.b_id     = w_id_q;
    assign slv.b_resp   = b_resp_q;
    assign slv.b_user   = '0;
    assign slv.ar_ready = ar_ready_q;
    assign slv.r_valid  = r_valid_q;
    assign slv.r_last   = r_last_q;
    assign slv.r_data   = r_data_q;
    assign slv.r_resp   = r_resp_q;
    assign slv.r_id     = r_id_q;
    assign slv.r_user   = '0;
endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 slave (responder) that terminates the master-side traffic issued by the core on its memory or MMIO port, backed by an internal word-addressed SRAM array.
- Used as a simulation/FPGA DRAM stand-in and as a scratchpad on the peripheral crossbar.
- Read and write channels are independent FSMs. Each channel has one outstanding transaction, with full INCR/FIXED burst support and per-beat error reporting.

Parameters:
- AXI_ID_WIDTH, 4, width of aw_id/ar_id/b_id/r_id
- AXI_ADDR_WIDTH, 64, address width
- AXI_DATA_WIDTH, 64, data width; DATA_BYTES = AXI_DATA_WIDTH/8, a power of two ≥ 1
- MEM_WORDS, 1024, SRAM depth in AXI_DATA_WIDTH words, a power of two

Ports:
- clk  input  1  clock; all logic is on the rising edge
- rst_n  input  1  synchronous, active-low reset
- slv  AXI_BUS.Slave  (parameterised as above)  AXI4 slave port carrying the AW/W/B/AR/R channels. *_user outputs are driven 0; lock/cache/prot/qos/region inputs are ignored.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Both FSMs go to IDLE; aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last all 0 while rst_n is low.
  - b_id, b_resp, r_id, r_data, r_resp all 0.
  - SRAM contents are NOT cleared.
  - Reset mid-burst aborts the burst: no further beats and no B is issued for the aborted transaction.
- Address decode:
  - Word index = addr[log2(MEM_WORDS)+log2(DATA_BYTES)-1 : log2(DATA_BYTES)].
  - A beat is in range iff all addr bits above that field are 0.
- Burst addressing:
  - Beat 0 uses the AxADDR as given.
  - INCR (2'b01): each later beat uses (previous addr aligned down to 2^size) + 2^size.
  - FIXED (2'b00): every beat uses beat-0 addr.
  - WRAP (2'b10) or 2'b11: every beat is an error.
- Beat count is len+1, from 1 to 256; the internal 8-bit counter is compared to len.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready=1. On aw handshake, latch id/addr/len/size/burst, clear the err flag, and enter W_DATA next cycle.
  - W_DATA: w_ready=1. On each w handshake, for an in-range beat with legal burst, write bytes where w_strb[i]=1 at the clock edge; otherwise set err.
  - W_DATA, last-beat mismatch: err is also set if w_last ≠ (counter==len).
  - W_DATA, exit: the burst ends on counter==len, regardless of w_last.
  - W_RESP: b_valid=1, b_id=latched id, b_resp=err ? 2'b10 (SLVERR) : 2'b00. Hold until b_ready, then return to W_IDLE on the next cycle.
  - W beats presented before AW are not accepted (w_ready=0 in W_IDLE).
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ar_ready=1. On ar handshake, latch fields and enter R_DATA next cycle. Minimum ar-to-first-r latency is 1 cycle.
  - R_DATA: r_valid=1, r_id=latched id, r_last=(counter==len).
  - R_DATA, in-range beat with legal burst: r_data = SRAM[word], r_resp=2'b00.
  - R_DATA, any other beat: r_data=0, r_resp=2'b10.
  - All R outputs stay stable while r_valid && !r_ready. Advance the beat on handshake; after the last-beat handshake return to R_IDLE.
- Read/write collision: a write and a read of the same word in the same cycle return the OLD data on R; the new data is visible from the next cycle.
- Exclusive access (lock=1) is treated as normal; OKAY is returned, never EXOKAY.
- Throughput: 1 beat/cycle per channel with ready/valid continuously high. Idle bubble: 1 cycle between bursts (B->AW, last R->AR).

Test Plan:
- Single write then read: AW addr=0x40, len=0, size=3, INCR; W data=0xDEADBEEF_01234567, strb=0xFF -> B OKAY with matching id. Then AR addr=0x40 -> R data=0xDEADBEEF_01234567, OKAY, r_last=1.
- INCR burst: write len=3 at 0x100, data 1..4 -> reads of 0x100/0x108/0x110/0x118 return 1,2,3,4; r_last only on beat 4. Random r_ready stalls: data held stable during each stall.
- Partial strobe: prior word 0xFFFF_FFFF_FFFF_FFFF; write 0 with strb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- Out of range: AR addr=MEM_WORDS*8 (0x2000 default), len=1 -> two beats with r_resp=SLVERR, r_data=0. Write len=1 straddling 0x1FF8 (beat 0 in range, beat 1 out) -> beat 0 written, B=SLVERR.
- WRAP burst (burst=2'b10), len=1 -> both R beats SLVERR; a write with WRAP -> no SRAM change, B=SLVERR. Write with w_last=1 on beat 0 of len=1 -> two beats consumed, B=SLVERR.
- Reset mid-operation: deassert rst_n during beat 2 of a 4-beat read -> next cycle r_valid=0, ar_ready=0. After release, ar_ready=1 and no stale R beat appears. Data previously written is still readable.
